// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/note-off events onto NUM_VOICES voice slots
// (retrigger, free voice, or steal) and drives per-voice gate, note index and trigger.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = 7,
   parameter int AGE_W      = 4
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic                        ev_valid,
   output logic                        ev_ready,
   input  logic                        ev_on,
   input  logic [IDX_W-1:0]            ev_note,
   input  logic                        all_off,
   input  logic [NUM_VOICES-1:0]       voice_done,
   output logic [NUM_VOICES-1:0]       voice_gate,
   output logic [NUM_VOICES-1:0]       voice_trig,
   output logic [NUM_VOICES*IDX_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]       voice_busy,
   output logic [3:0]                  active_count,
   output logic [1:0]                  dbg_state
);

   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_APPLY  = 2'd2;

   localparam logic [1:0] ACT_NOP = 2'd0;
   localparam logic [1:0] ACT_ON  = 2'd1;
   localparam logic [1:0] ACT_OFF = 2'd2;

   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   logic [1:0]            state;
   logic                  lat_on;
   logic [IDX_W-1:0]      lat_note;
   logic [1:0]            act_q;
   logic [VW-1:0]         tgt_q;

   logic [NUM_VOICES-1:0] gate_q, busy_q, trig_q;
   logic [IDX_W-1:0]      note_q [NUM_VOICES];
   logic [AGE_W-1:0]      age_q  [NUM_VOICES];

   logic [NUM_VOICES-1:0] gate_n, busy_n, trig_n;
   logic [IDX_W-1:0]      note_n [NUM_VOICES];
   logic [AGE_W-1:0]      age_n  [NUM_VOICES];
   logic [3:0]            cnt_n;

   logic                  hit_match, hit_free, hit_rel, hit_gtd, hit_off;
   logic [VW-1:0]         match_idx, free_idx, rel_idx, gtd_idx, off_idx;
   logic [AGE_W-1:0]      rel_age, gtd_age;
   logic [1:0]            sel_act;
   logic [VW-1:0]         sel_tgt;

   // Handshake: an event transfers on a rising Clk edge where ev_valid && ev_ready;
   // the producer holds ev_on/ev_note stable until then. Ready only in IDLE without panic.
   assign ev_ready  = Reset_n && (state == ST_IDLE) && !all_off;
   assign dbg_state = state;

   assign voice_gate = gate_q;
   assign voice_busy = busy_q;
   assign voice_trig = trig_q;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
      assign voice_note[g*IDX_W +: IDX_W] = note_q[g];
   end

   // Candidate search; strict '>' on age keeps ties on the lowest index.
   always_comb begin
      hit_match = 1'b0;  match_idx = '0;
      hit_free  = 1'b0;  free_idx  = '0;
      hit_rel   = 1'b0;  rel_idx   = '0;  rel_age = '0;
      hit_gtd   = 1'b0;  gtd_idx   = '0;  gtd_age = '0;
      hit_off   = 1'b0;  off_idx   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (busy_q[i] && (note_q[i] == lat_note) && !hit_match) begin
            hit_match = 1'b1;
            match_idx = VW'(i);
         end
         if (!busy_q[i] && !hit_free) begin
            hit_free = 1'b1;
            free_idx = VW'(i);
         end
         if (busy_q[i] && !gate_q[i] && (!hit_rel || (age_q[i] > rel_age))) begin
            hit_rel = 1'b1;
            rel_idx = VW'(i);
            rel_age = age_q[i];
         end
         if (gate_q[i] && (!hit_gtd || (age_q[i] > gtd_age))) begin
            hit_gtd = 1'b1;
            gtd_idx = VW'(i);
            gtd_age = age_q[i];
         end
         if (gate_q[i] && (note_q[i] == lat_note) && !hit_off) begin
            hit_off = 1'b1;
            off_idx = VW'(i);
         end
      end

      sel_act = ACT_NOP;
      sel_tgt = '0;
      if (lat_on) begin
         sel_act = ACT_ON;
         if (hit_match)     sel_tgt = match_idx;
         else if (hit_free) sel_tgt = free_idx;
         else if (hit_rel)  sel_tgt = rel_idx;
         else               sel_tgt = gtd_idx;
      end else if (hit_off) begin
         sel_act = ACT_OFF;
         sel_tgt = off_idx;
      end
   end

   // Voice next state; the APPLY commit is last so it overrides a coincident done pulse.
   always_comb begin
      gate_n = gate_q;
      busy_n = busy_q;
      trig_n = '0;
      cnt_n  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         note_n[i] = note_q[i];
         age_n[i]  = age_q[i];
      end

      if ((state == ST_APPLY) && (act_q == ACT_ON)) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (busy_q[i] && (age_q[i] != AGE_MAX)) age_n[i] = age_q[i] + 1'b1;
         end
      end

      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_done[i] && !gate_q[i]) begin
            busy_n[i] = 1'b0;
            age_n[i]  = '0;
         end
      end

      if ((state == ST_IDLE) && all_off) gate_n = '0;

      if (state == ST_APPLY) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (VW'(i) == tgt_q) begin
               if (act_q == ACT_ON) begin
                  gate_n[i] = 1'b1;
                  busy_n[i] = 1'b1;
                  trig_n[i] = 1'b1;
                  note_n[i] = lat_note;
                  age_n[i]  = '0;
               end else if (act_q == ACT_OFF) begin
                  gate_n[i] = 1'b0;
               end
            end
         end
      end

      for (int i = 0; i < NUM_VOICES; i++) begin
         cnt_n = cnt_n + {3'b000, busy_n[i]};
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= ST_IDLE;
         lat_on       <= 1'b0;
         lat_note     <= '0;
         act_q        <= ACT_NOP;
         tgt_q        <= '0;
         gate_q       <= '0;
         busy_q       <= '0;
         trig_q       <= '0;
         active_count <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= '0;
            age_q[i]  <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (!all_off && ev_valid) begin
                  lat_on   <= ev_on;
                  lat_note <= ev_note;
                  state    <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               act_q <= sel_act;
               tgt_q <= sel_tgt;
               state <= ST_APPLY;
            end
            ST_APPLY: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         gate_q       <= gate_n;
         busy_q       <= busy_n;
         trig_q       <= trig_n;
         active_count <= cnt_n;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= note_n[i];
            age_q[i]  <= age_n[i];
         end
      end
   end

endmodule
